// File: rtl/rv_muldiv_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rv_muldiv_arbiter
//  Purpose  : Round-robin front-end sharing one muldiv unit among NUM_REQS
//             requesters, with a credit cap on in-flight divides.
//  Options  : MULDIV_ARB_PERF_EN adds stall / divide-block perf counters.
//  Revision : 1.0  initial release
// ============================================================================

`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif
`ifndef NW_BITS
`define NW_BITS 2
`endif
`ifndef NR_BITS
`define NR_BITS 5
`endif
`ifndef INST_MUL_BITS
`define INST_MUL_BITS 3
`endif
`ifndef INST_MUL_IS_DIV
`define INST_MUL_IS_DIV(op) (op[2])
`endif

module rv_muldiv_arbiter #(
    parameter int NUM_REQS    = 4,
    parameter int REQW        = $clog2(NUM_REQS),
    parameter int TAGW        = 64 + `NW_BITS + `NUM_THREADS + 32 + `NR_BITS + 1,
    parameter int DIV_CREDITS = 2
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_REQS-1:0]                   req_valid,
    input  logic [NUM_REQS*`INST_MUL_BITS-1:0]    req_alu_op,
    input  logic [NUM_REQS*TAGW-1:0]              req_tag,
    input  logic [NUM_REQS*`NUM_THREADS*32-1:0]   req_in1,
    input  logic [NUM_REQS*`NUM_THREADS*32-1:0]   req_in2,
    output logic [NUM_REQS-1:0]                   req_ready,
    output logic                                  out_valid,
    output logic [`INST_MUL_BITS-1:0]             out_alu_op,
    output logic [TAGW-1:0]                       out_tag,
    output logic [REQW-1:0]                       out_req_id,
    output logic [`NUM_THREADS*32-1:0]            out_in1,
    output logic [`NUM_THREADS*32-1:0]            out_in2,
    input  logic                                  out_ready,
`ifdef MULDIV_ARB_PERF_EN
    output logic [31:0]                           perf_stall_cycles,
    output logic [31:0]                           perf_div_block_cycles,
`endif
    input  logic                                  div_done
);

    localparam int            c_op_w        = `INST_MUL_BITS;
    localparam int            c_data_w      = `NUM_THREADS * 32;
    localparam logic [3:0]    c_div_credits = 4'(DIV_CREDITS);
    localparam logic [REQW:0] c_num_reqs    = (REQW+1)'(NUM_REQS);

    logic                  r_out_valid;
    logic [c_op_w-1:0]     r_out_alu_op;
    logic [TAGW-1:0]       r_out_tag;
    logic [REQW-1:0]       r_out_req_id;
    logic [c_data_w-1:0]   r_out_in1;
    logic [c_data_w-1:0]   r_out_in2;
    logic [REQW-1:0]       r_rr_ptr;
    logic [3:0]            r_div_cnt;

    logic [NUM_REQS-1:0]   w_is_div;
    logic [NUM_REQS-1:0]   w_elig;
    logic [2*NUM_REQS-1:0] w_elig_dbl;
    logic                  w_credit_ok;
    logic                  w_load_en;
    logic                  w_grant_valid;
    logic [REQW-1:0]       w_rot_off;
    logic [REQW:0]         w_idx_sum;
    logic [REQW-1:0]       w_grant_idx;
    logic [REQW-1:0]       w_rr_next;
    logic [c_op_w-1:0]     w_sel_op;
    logic [TAGW-1:0]       w_sel_tag;
    logic [c_data_w-1:0]   w_sel_in1;
    logic [c_data_w-1:0]   w_sel_in2;
    logic                  w_sel_is_div;
    logic                  w_div_inc;
    logic                  w_div_dec;

    assign w_credit_ok = (r_div_cnt < c_div_credits);
    assign w_load_en   = !r_out_valid || out_ready;

    for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_req
        logic [c_op_w-1:0] w_op;
        assign w_op          = req_alu_op[gi*c_op_w +: c_op_w];
        assign w_is_div[gi]  = `INST_MUL_IS_DIV(w_op);
        assign w_elig[gi]    = req_valid[gi] && (!w_is_div[gi] || w_credit_ok);
        assign req_ready[gi] = reset && w_load_en && w_grant_valid && (w_grant_idx == REQW'(gi));
    end

    // Rotate eligibility so bit 0 is the requester at rr_ptr, then take the lowest set bit.
    assign w_elig_dbl = {w_elig, w_elig} >> r_rr_ptr;

    always_comb begin
        w_grant_valid = 1'b0;
        w_rot_off     = '0;
        for (int k = NUM_REQS - 1; k >= 0; k--) begin
            if (w_elig_dbl[k]) begin
                w_grant_valid = 1'b1;
                w_rot_off     = REQW'(k);
            end
        end
        w_idx_sum   = {1'b0, r_rr_ptr} + {1'b0, w_rot_off};
        w_grant_idx = (w_idx_sum >= c_num_reqs) ? REQW'(w_idx_sum - c_num_reqs)
                                                : w_idx_sum[REQW-1:0];
        w_rr_next   = (w_grant_idx == REQW'(NUM_REQS - 1)) ? '0 : w_grant_idx + REQW'(1);
    end

    always_comb begin
        w_sel_op     = '0;
        w_sel_tag    = '0;
        w_sel_in1    = '0;
        w_sel_in2    = '0;
        w_sel_is_div = 1'b0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (w_grant_idx == REQW'(i)) begin
                w_sel_op     = req_alu_op[i*c_op_w +: c_op_w];
                w_sel_tag    = req_tag[i*TAGW +: TAGW];
                w_sel_in1    = req_in1[i*c_data_w +: c_data_w];
                w_sel_in2    = req_in2[i*c_data_w +: c_data_w];
                w_sel_is_div = w_is_div[i];
            end
        end
    end

    assign w_div_inc = w_load_en && w_grant_valid && w_sel_is_div;
    assign w_div_dec = div_done && (r_div_cnt != 4'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_valid  <= 1'b0;
            r_out_alu_op <= '0;
            r_out_tag    <= '0;
            r_out_req_id <= '0;
            r_out_in1    <= '0;
            r_out_in2    <= '0;
            r_rr_ptr     <= '0;
            r_div_cnt    <= 4'd0;
        end else begin
            if (w_load_en) begin
                if (w_grant_valid) begin
                    r_out_valid  <= 1'b1;
                    r_out_alu_op <= w_sel_op;
                    r_out_tag    <= w_sel_tag;
                    r_out_req_id <= w_grant_idx;
                    r_out_in1    <= w_sel_in1;
                    r_out_in2    <= w_sel_in2;
                    r_rr_ptr     <= w_rr_next;
                end else begin
                    r_out_valid  <= 1'b0;
                end
            end
            if (w_div_inc && !w_div_dec) begin
                r_div_cnt <= r_div_cnt + 4'd1;
            end else if (!w_div_inc && w_div_dec) begin
                r_div_cnt <= r_div_cnt - 4'd1;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_alu_op = r_out_alu_op;
    assign out_tag    = r_out_tag;
    assign out_req_id = r_out_req_id;
    assign out_in1    = r_out_in1;
    assign out_in2    = r_out_in2;

`ifdef MULDIV_ARB_PERF_EN
    logic        w_div_blocked;
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_div_block;

    assign w_div_blocked = (|(req_valid & w_is_div)) && !w_credit_ok;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_perf_stall     <= 32'd0;
            r_perf_div_block <= 32'd0;
        end else begin
            if (r_out_valid && !out_ready) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if (w_div_blocked) begin
                r_perf_div_block <= r_perf_div_block + 32'd1;
            end
        end
    end

    assign perf_stall_cycles     = r_perf_stall;
    assign perf_div_block_cycles = r_perf_div_block;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rv_muldiv_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rv_muldiv_arbiter
//  Purpose  : Self-checking bench for rv_muldiv_arbiter against a queue-free
//             behavioural round-robin/credit model.
//  Revision : 1.0  initial release
// ============================================================================

module tb_rv_muldiv_arbiter;

    localparam int N    = 4;
    localparam int CRED = 2;
    localparam int TAGW = 108;
    localparam int DW   = 128;
    localparam int OPW  = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // Per-requester stimulus for the 4-way instance
    logic             t_v   [N];
    logic [OPW-1:0]   t_op  [N];
    logic [TAGW-1:0]  t_tag [N];
    logic [DW-1:0]    t_a   [N];
    logic [DW-1:0]    t_b   [N];

    logic [N-1:0]      req_valid;
    logic [N*OPW-1:0]  req_alu_op;
    logic [N*TAGW-1:0] req_tag;
    logic [N*DW-1:0]   req_in1, req_in2;
    logic [N-1:0]      req_ready;
    logic              out_valid, out_ready, div_done;
    logic [OPW-1:0]    out_alu_op;
    logic [TAGW-1:0]   out_tag;
    logic [1:0]        out_req_id;
    logic [DW-1:0]     out_in1, out_in2;
`ifdef MULDIV_ARB_PERF_EN
    logic [31:0]       perf_stall_cycles, perf_div_block_cycles;
    logic [31:0]       p3_stall, p3_blk;
`endif

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign req_valid[g]              = t_v[g];
        assign req_alu_op[g*OPW +: OPW]  = t_op[g];
        assign req_tag[g*TAGW +: TAGW]   = t_tag[g];
        assign req_in1[g*DW +: DW]       = t_a[g];
        assign req_in2[g*DW +: DW]       = t_b[g];
    end

    rv_muldiv_arbiter #(.NUM_REQS(N), .DIV_CREDITS(CRED)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_alu_op(req_alu_op), .req_tag(req_tag),
        .req_in1(req_in1), .req_in2(req_in2), .req_ready(req_ready),
        .out_valid(out_valid), .out_alu_op(out_alu_op), .out_tag(out_tag),
        .out_req_id(out_req_id), .out_in1(out_in1), .out_in2(out_in2),
        .out_ready(out_ready),
`ifdef MULDIV_ARB_PERF_EN
        .perf_stall_cycles(perf_stall_cycles), .perf_div_block_cycles(perf_div_block_cycles),
`endif
        .div_done(div_done)
    );

    // Three-requester instance for the wrap-around check
    logic [2:0]        v3, ready3;
    logic [3*OPW-1:0]  op3;
    logic [3*TAGW-1:0] tag3;
    logic [3*DW-1:0]   a3, b3;
    logic              ov3;
    logic [OPW-1:0]    oop3;
    logic [TAGW-1:0]   otag3;
    logic [1:0]        id3;
    logic [DW-1:0]     oa3, ob3;

    rv_muldiv_arbiter #(.NUM_REQS(3), .DIV_CREDITS(CRED)) dut3 (
        .clk(clk), .reset(reset),
        .req_valid(v3), .req_alu_op(op3), .req_tag(tag3),
        .req_in1(a3), .req_in2(b3), .req_ready(ready3),
        .out_valid(ov3), .out_alu_op(oop3), .out_tag(otag3),
        .out_req_id(id3), .out_in1(oa3), .out_in2(ob3),
        .out_ready(1'b1),
`ifdef MULDIV_ARB_PERF_EN
        .perf_stall_cycles(p3_stall), .perf_div_block_cycles(p3_blk),
`endif
        .div_done(1'b0)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic            m_ov;
    logic [OPW-1:0]  m_op;
    logic [TAGW-1:0] m_tag;
    logic [DW-1:0]   m_a, m_b;
    int              m_id, m_rr, m_div;
    logic [31:0]     m_stall, m_blk;
    logic [N-1:0]    s_ready, e_ready;

    task automatic model_reset();
        m_ov = 0; m_op = '0; m_tag = '0; m_a = '0; m_b = '0;
        m_id = 0; m_rr = 0; m_div = 0; m_stall = 0; m_blk = 0;
    endtask

    function automatic int model_grant();
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_rr + k) % N;
            if (t_v[i] && (t_op[i] < 4 || m_div < CRED)) return i;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] model_ready(input logic o);
        int g;
        g = model_grant();
        if ((!m_ov || o) && g >= 0) return N'(1) << g;
        return '0;
    endfunction

    task automatic model_step(input logic o, input logic d);
        int g;
        int inc;
        logic blk;
        g = model_grant();
        inc = 0;
        blk = 0;
        for (int i = 0; i < N; i++) if (t_v[i] && t_op[i] >= 4 && m_div >= CRED) blk = 1;
        if (m_ov && !o) m_stall = m_stall + 1;
        if (blk) m_blk = m_blk + 1;
        if (!m_ov || o) begin
            if (g >= 0) begin
                m_ov = 1; m_op = t_op[g]; m_tag = t_tag[g]; m_a = t_a[g]; m_b = t_b[g];
                m_id = g; m_rr = (g + 1) % N; inc = (t_op[g] >= 4) ? 1 : 0;
            end else begin
                m_ov = 0;
            end
        end
        m_div = m_div + inc - ((d && m_div > 0) ? 1 : 0);
    endtask

    // One clock: sample req_ready before the edge, advance the model with the edge.
    task automatic cyc(input logic o, input logic d);
        out_ready = o;
        div_done  = d;
        #3;
        s_ready = req_ready;
        e_ready = model_ready(o);
        @(posedge clk);
        model_step(o, d);
        #1;
        div_done = 1'b0;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N; i++) begin
            t_v[i] = 0; t_op[i] = '0; t_tag[i] = '0; t_a[i] = '0; t_b[i] = '0;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < N; i++) begin t_v[i] = 1; t_op[i] = 3'd0; end
        out_ready = 1; div_done = 0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_cmp++; if (out_tag !== '0 || out_in1 !== '0 || out_req_id !== 2'd0) begin
            n_err++; $display("FAIL reset_out_data: tag %0h in1 %0h id %0d expected all 0", out_tag, out_in1, out_req_id); end
        clear_reqs();
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_wrap();
        v3 = 3'b100; op3 = '0; tag3 = '0; a3 = '0; b3 = '0;
        tag3[2*TAGW +: TAGW] = TAGW'(2);
        #3;
        n_cmp++; if (ready3 !== 3'b100) begin n_err++; $display("FAIL wrap_ready_r2: got %b expected 100", ready3); end
        @(posedge clk); #1;
        n_cmp++; if (ov3 !== 1'b1 || id3 !== 2'd2) begin n_err++; $display("FAIL wrap_grant_r2: got v%b id %0d expected v1 id 2", ov3, id3); end
        n_cmp++; if (dut3.r_rr_ptr !== 2'd0) begin n_err++; $display("FAIL wrap_rr_ptr: got %0d expected 0", dut3.r_rr_ptr); end
        v3 = 3'b011;
        #3;
        n_cmp++; if (ready3 !== 3'b001) begin n_err++; $display("FAIL wrap_ready_r0: got %b expected 001", ready3); end
        @(posedge clk); #1;
        n_cmp++; if (id3 !== 2'd0) begin n_err++; $display("FAIL wrap_grant_r0: got %0d expected 0", id3); end
        @(posedge clk); #1;
        n_cmp++; if (id3 !== 2'd1) begin n_err++; $display("FAIL wrap_grant_r1: got %0d expected 1", id3); end
        v3 = 3'b000;
        @(posedge clk); #1;
    endtask

    task automatic test_fairness();
        int cnt [N];
        for (int i = 0; i < N; i++) begin
            cnt[i] = 0; t_v[i] = 1; t_op[i] = 3'd0;
            t_tag[i] = TAGW'({$urandom, $urandom, $urandom, $urandom});
            t_a[i] = {$urandom, $urandom, $urandom, $urandom};
            t_b[i] = {$urandom, $urandom, $urandom, $urandom};
        end
        for (int c = 0; c < 8; c++) begin
            cyc(1, 0);
            for (int i = 0; i < N; i++) if (s_ready[i]) cnt[i]++;
            n_cmp++; if (s_ready !== e_ready) begin n_err++; $display("FAIL fair_ready c%0d: got %b expected %b", c, s_ready, e_ready); end
            n_cmp++; if (out_req_id !== 2'(c % N) || out_tag !== t_tag[c % N]) begin
                n_err++; $display("FAIL fair_order c%0d: got id %0d expected %0d", c, out_req_id, c % N); end
        end
        for (int i = 0; i < N; i++) begin
            n_cmp++; if (cnt[i] != 2) begin n_err++; $display("FAIL fair_ready_count r%0d: got %0d expected 2", i, cnt[i]); end
        end
    endtask

    task automatic test_backpressure();
        clear_reqs();
        t_v[2] = 1; t_tag[2] = TAGW'(12'hABC);
        cyc(1, 0);
        n_cmp++; if (out_valid !== 1'b1 || out_req_id !== 2'd2) begin n_err++; $display("FAIL bp_grant: got v%b id %0d expected v1 id 2", out_valid, out_req_id); end
        for (int i = 0; i < N; i++) t_v[i] = 1;
        for (int c = 0; c < 5; c++) begin
            cyc(0, 0);
            n_cmp++; if (out_valid !== 1'b1 || out_tag !== TAGW'(12'hABC) || s_ready !== 4'b0) begin
                n_err++; $display("FAIL bp_hold c%0d: got v%b tag %0h ready %b expected v1 tag abc ready 0000", c, out_valid, out_tag, s_ready); end
        end
        cyc(1, 0);
        n_cmp++; if (out_req_id !== 2'd3) begin n_err++; $display("FAIL bp_next_grant: got %0d expected 3", out_req_id); end
        clear_reqs();
        cyc(1, 0);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_credits();
        int exp_id [8] = '{0, 1, 0, 1, 1, 1, 1, 1};
        int divs;
        divs = 0;
        clear_reqs();
        t_v[0] = 1; t_op[0] = 3'd4;
        t_v[1] = 1; t_op[1] = 3'd0;
        for (int c = 0; c < 8; c++) begin
            cyc(1, 0);
            if (s_ready[0]) divs++;
            n_cmp++; if (out_req_id !== 2'(exp_id[c]) || out_valid !== 1'b1) begin
                n_err++; $display("FAIL credit_seq c%0d: got id %0d expected %0d", c, out_req_id, exp_id[c]); end
        end
        n_cmp++; if (divs != 2) begin n_err++; $display("FAIL credit_div_count: got %0d expected 2", divs); end
        cyc(1, 1);
        n_cmp++; if (out_req_id !== 2'd1) begin n_err++; $display("FAIL credit_done_cycle: got %0d expected 1", out_req_id); end
        cyc(1, 0);
        n_cmp++; if (out_req_id !== 2'd0 || out_alu_op !== 3'd4) begin n_err++; $display("FAIL credit_third_div: got id %0d op %0d expected id 0 op 4", out_req_id, out_alu_op); end
        n_cmp++; if (dut.r_div_cnt !== 4'd2) begin n_err++; $display("FAIL credit_cnt: got %0d expected 2", dut.r_div_cnt); end
        clear_reqs();
        cyc(1, 0);
    endtask

    task automatic test_simultaneous();
        int acc;
        cyc(1, 1);
        t_v[0] = 1; t_op[0] = 3'd5;
        cyc(1, 1);
        n_cmp++; if (s_ready[0] !== 1'b1) begin n_err++; $display("FAIL sim_div_accept: got %b expected 1", s_ready[0]); end
        n_cmp++; if (dut.r_div_cnt !== 4'd1) begin n_err++; $display("FAIL sim_inc_dec: got %0d expected 1", dut.r_div_cnt); end
        clear_reqs();
        cyc(1, 1);
        cyc(1, 1);
        n_cmp++; if (dut.r_div_cnt !== 4'd0) begin n_err++; $display("FAIL sim_underflow: got %0d expected 0", dut.r_div_cnt); end
        acc = 0;
        t_v[0] = 1; t_op[0] = 3'd6;
        t_v[2] = 1; t_op[2] = 3'd7;
        for (int c = 0; c < 5; c++) begin
            cyc(1, 0);
            acc += int'(s_ready[0]) + int'(s_ready[2]);
        end
        n_cmp++; if (acc != CRED) begin n_err++; $display("FAIL sim_capacity: got %0d accepts expected %0d", acc, CRED); end
        clear_reqs();
        cyc(1, 1);
        cyc(1, 1);
    endtask

    task automatic test_random();
        logic o, d;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                t_v[i]   = ($urandom_range(0, 2) != 0);
                t_op[i]  = OPW'($urandom_range(0, 7));
                t_tag[i] = TAGW'({$urandom, $urandom, $urandom, $urandom});
                t_a[i]   = {$urandom, $urandom, $urandom, $urandom};
                t_b[i]   = {$urandom, $urandom, $urandom, $urandom};
            end
            o = ($urandom_range(0, 3) != 0);
            d = ($urandom_range(0, 2) == 0);
            cyc(o, d);
            n_cmp++; if (s_ready !== e_ready) begin n_err++; $display("FAIL rand_ready c%0d: got %b expected %b", c, s_ready, e_ready); end
            n_cmp++; if (out_valid !== m_ov || out_req_id !== 2'(m_id) || out_alu_op !== m_op) begin
                n_err++; $display("FAIL rand_ctrl c%0d: got v%b id %0d op %0d expected v%b id %0d op %0d", c, out_valid, out_req_id, out_alu_op, m_ov, m_id, m_op); end
            n_cmp++; if (out_tag !== m_tag || out_in1 !== m_a || out_in2 !== m_b) begin
                n_err++; $display("FAIL rand_data c%0d: got tag %0h expected %0h", c, out_tag, m_tag); end
            n_cmp++; if (dut.r_div_cnt !== 4'(m_div)) begin n_err++; $display("FAIL rand_div_cnt c%0d: got %0d expected %0d", c, dut.r_div_cnt, m_div); end
        end
`ifdef MULDIV_ARB_PERF_EN
        n_cmp++; if (perf_stall_cycles !== m_stall) begin n_err++; $display("FAIL perf_stall: got %0d expected %0d", perf_stall_cycles, m_stall); end
        n_cmp++; if (perf_div_block_cycles !== m_blk) begin n_err++; $display("FAIL perf_div_block: got %0d expected %0d", perf_div_block_cycles, m_blk); end
`endif
        clear_reqs();
    endtask

    task automatic test_async_reset();
        int acc;
        for (int c = 0; c < 4; c++) cyc(1, 1);
        t_v[1] = 1; t_op[1] = 3'd4; t_tag[1] = TAGW'(77);
        cyc(1, 0);
        cyc(0, 0);
        n_cmp++; if (out_valid !== 1'b1 || dut.r_div_cnt !== 4'(m_div)) begin
            n_err++; $display("FAIL ares_pre: got v%b cnt %0d expected v1 cnt %0d", out_valid, dut.r_div_cnt, m_div); end
        #2;
        reset = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ares_out_valid: got %b expected 0", out_valid); end
        n_cmp++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL ares_req_ready: got %b expected 0000", req_ready); end
        @(posedge clk); #1;
        reset = 1'b1;
        model_reset();
        n_cmp++; if (dut.r_div_cnt !== 4'd0) begin n_err++; $display("FAIL ares_div_cnt: got %0d expected 0", dut.r_div_cnt); end
`ifdef MULDIV_ARB_PERF_EN
        n_cmp++; if (perf_stall_cycles !== 32'd0 || perf_div_block_cycles !== 32'd0) begin
            n_err++; $display("FAIL ares_perf: got %0d/%0d expected 0/0", perf_stall_cycles, perf_div_block_cycles); end
`endif
        acc = 0;
        t_v[3] = 1; t_op[3] = 3'd4;
        for (int c = 0; c < 4; c++) begin
            cyc(1, 0);
            acc += int'(s_ready[1]) + int'(s_ready[3]);
        end
        n_cmp++; if (acc != CRED) begin n_err++; $display("FAIL ares_credits_restored: got %0d expected %0d", acc, CRED); end
        clear_reqs();
        cyc(1, 0);
    endtask

    initial begin
        out_ready = 1'b1;
        div_done  = 1'b0;
        v3 = '0; op3 = '0; tag3 = '0; a3 = '0; b3 = '0;
        clear_reqs();
        model_reset();
        test_reset();
        test_wrap();
        test_fairness();
        test_backpressure();
        test_credits();
        test_simultaneous();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
